rounder_arbiter: RTL
====================

Name: rounder_arbiter

Overview:
Shares one round-and-saturate stage between NUM_REQ product sources, such as parallel MAC lanes. Each source emits full-width signed Q(2I).(2F) products. The block selects one source per cycle by round-robin and rounds the product to signed Q(I).(F), saturating on overflow. The result leaves on a single valid/ready stream tagged with the source index.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
INT_BITS, 7, integer bits of the output format (sign included)
FRAC_BITS, 9, fraction bits of the output format
W (derived, localparam), INT_BITS+FRAC_BITS, output width; input width is 2*W
IDW (derived, localparam), $clog2(NUM_REQ), width of the requester index

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester product valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_data  in  NUM_REQ*2*W  packed products; requester i occupies bits [i*2W +: 2W]
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  W  rounded, saturated result
out_id  out  IDW  index of the requester that produced the result
out_sat  out  1  result was clipped

Behaviour:
- Pipeline:
  - S1 is the capture register: 2W-bit product, id, valid.
  - S2 is the output register: out_data, out_id, out_sat, out_valid.
  - Rounding is combinational from S1 into S2.
- Transfers:
  - Input transfer for requester i: req_valid[i] && req_ready[i].
  - Output transfer: out_valid && out_ready.
- Stall rules:
  - s2_adv = !out_valid || out_ready.
  - s1_free = !s1_valid || s2_adv.
- S2 update: when s2_adv, S2 loads S1 (out_valid <= s1_valid). Otherwise S2 holds. out_data, out_id and out_sat are stable while out_valid && !out_ready.
- Latency and throughput:
  - Input transfer at cycle t gives out_valid at t+2 when there is no backpressure.
  - Throughput is 1 result per cycle.
- Arbitration:
  - Round-robin with pointer last_id.
  - The search starts at last_id+1 modulo NUM_REQ and grants the first asserted req_valid.
  - req_ready[i] = grant[i] && s1_free.
  - last_id updates only on an input transfer.
  - With no valid requests there is no grant and the pointer holds.
- Handshake:
  - Requesters keep req_valid and req_data stable until their transfer.
  - req_ready may depend combinationally on req_valid.
  - req_valid must not depend on req_ready.
- Arithmetic:
  - r = (in >>> FRAC_BITS) + in[FRAC_BITS-1], computed at 2W-FRAC_BITS+1 bits, sign-extended. This is round-half-up, toward +inf on ties.
  - If r > 2^(W-1)-1: out_data = {0, all 1s}, out_sat = 1.
  - If r < -2^(W-1): out_data = {1, all 0s}, out_sat = 1.
  - Otherwise: out_data = r[W-1:0], out_sat = 0.
- Reset (asynchronous, any cycle, including mid-stall):
  - s1_valid = 0, out_valid = 0, out_data = 0, out_id = 0, out_sat = 0.
  - last_id = NUM_REQ-1, so requester 0 is granted first.
  - In-flight data is discarded.
- Simultaneous events:
  - Output transfer and new S1→S2 load in the same cycle: both happen, no bubble.
  - Full pipeline with out_ready = 0: every req_ready bit is 0.

Optional Feature:
- Macro ROUNDER_ARB_SAT_CNT_EN.
- When defined, the block adds:
  - input sat_clr (1 bit);
  - output sat_count (16 bits).
- sat_count behaviour:
  - Increments on each output transfer with out_sat = 1.
  - Sticks at 0xFFFF.
  - sat_clr clears it synchronously; clear wins over a same-cycle increment.
  - Reset value is 0.
- When undefined, neither port nor the counter exists. All other behaviour is identical.

Test Plan:
- Defaults, requester 2 only, req_data = 0x0000_0300, out_ready = 1 -> out_valid two cycles after the transfer, out_data = 0x0002, out_id = 2, out_sat = 0.
- req_data = 0xFFFF_FF00 (-0.5 LSB tie) -> out_data = 0x0000. req_data = 0xFF00_0000 -> out_data = 0x8000, out_sat = 0.
- req_data = 0x0100_0000 -> 0x7FFF, out_sat = 1. req_data = 0xFE00_0000 -> 0x8000, out_sat = 1.
- All 4 requesters valid continuously, out_ready = 1 -> out_id sequence 0,1,2,3,0,1; one grant per cycle; no bubbles.
- Full pipeline, out_ready low for 3 cycles -> out_data/out_id held, all req_ready = 0, no result lost or duplicated after release. Assert rst mid-stall -> out_valid = 0 that cycle, next grant goes to requester 0.
- With ROUNDER_ARB_SAT_CNT_EN: 3 saturating transfers give sat_count = 3. Then sat_clr together with a saturating transfer -> sat_count = 0.

Source files
------------

// File: rtl/rounder_arbiter.sv
// Round-robin arbiter feeding a shared round-half-up/saturate stage, Q(2I).(2F) -> Q(I).(F).
// Optional saturation counter enabled by defining ROUNDER_ARB_SAT_CNT_EN.
module rounder_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned INT_BITS  = 7,
  parameter int unsigned FRAC_BITS = 9
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_REQ-1:0]                            req_valid,
  output logic [NUM_REQ-1:0]                            req_ready,
  input  logic [NUM_REQ*2*(INT_BITS+FRAC_BITS)-1:0]     req_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [INT_BITS+FRAC_BITS-1:0]                 out_data,
  output logic [$clog2(NUM_REQ)-1:0]                    out_id,
  output logic                                          out_sat
`ifdef ROUNDER_ARB_SAT_CNT_EN
  ,
  input  logic                                          sat_clr,
  output logic [15:0]                                   sat_count
`endif
);

  localparam int unsigned W   = INT_BITS + FRAC_BITS;
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned RW  = 2 * W - FRAC_BITS + 1;

  logic [IDW-1:0] last_id_q;
  logic           s1_valid_q;
  logic [2*W-1:0] s1_data_q;
  logic [IDW-1:0] s1_id_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [IDW-1:0] out_id_q;
  logic           out_sat_q;

  logic           s2_adv;
  logic           s1_free;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  int unsigned    idx;
  logic           in_xfer;

  assign s2_adv  = !out_valid_q || out_ready;
  assign s1_free = !s1_valid_q || s2_adv;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_id_q) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  assign in_xfer   = grant_any && s1_free;
  assign req_ready = in_xfer ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id_q  <= IDW'(NUM_REQ - 1);
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_id_q    <= '0;
    end else begin
      if (s1_free) s1_valid_q <= in_xfer;
      if (in_xfer) begin
        s1_data_q <= req_data[32'(grant_id)*2*W +: 2*W];
        s1_id_q   <= grant_id;
        last_id_q <= grant_id;
      end
    end
  end

  logic [RW-1:0] rnd;
  logic          sat_hi;
  logic          sat_lo;
  logic [W-1:0]  rnd_data;
  logic          rnd_sat;
  logic          unused_lsbs;

  assign unused_lsbs = ^s1_data_q[FRAC_BITS-2:0];

  // Arithmetic shift kept one bit wider than the shifted field so the +1 cannot wrap.
  always_comb begin
    rnd      = {s1_data_q[2*W-1], s1_data_q[2*W-1:FRAC_BITS]} + RW'(s1_data_q[FRAC_BITS-1]);
    sat_hi   = !rnd[RW-1] && (|rnd[RW-2:W-1]);
    sat_lo   = rnd[RW-1] && !(&rnd[RW-2:W-1]);
    rnd_sat  = sat_hi || sat_lo;
    rnd_data = rnd[W-1:0];
    if (sat_hi) rnd_data = {1'b0, {(W-1){1'b1}}};
    if (sat_lo) rnd_data = {1'b1, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_sat_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= rnd_data;
        out_id_q   <= s1_id_q;
        out_sat_q  <= rnd_sat;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_sat   = out_sat_q;

`ifdef ROUNDER_ARB_SAT_CNT_EN
  logic [15:0] sat_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count_q <= '0;
    end else if (sat_clr) begin
      sat_count_q <= '0;
    end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_q <= sat_count_q + 16'd1;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule
